// File: rtl/ifu_ibuf_if.sv
// Fetch-to-decode handshake bundle for the instruction buffer.
// slave = the buffer itself, master = fetch/decode side driving it.
interface ifu_ibuf_if #(
  parameter int BP_ADDR_W = 4
);
  logic                 enq_valid;
  logic                 enq_ready;
  logic [31:0]          enq_pc;
  logic [31:0]          enq_pc_plus;
  logic                 enq_ilen32;
  logic [31:0]          enq_inst;
  logic                 enq_bp_taken;
  logic                 enq_bp_match;
  logic [BP_ADDR_W-1:0] enq_bp_addr;
  logic [31:0]          enq_bp_pc;

  logic                 deq_valid;
  logic                 deq_ready;
  logic [31:0]          deq_pc;
  logic [31:0]          deq_pc_plus;
  logic                 deq_ilen32;
  logic [31:0]          deq_inst;
  logic                 deq_bp_taken;
  logic                 deq_bp_match;
  logic [BP_ADDR_W-1:0] deq_bp_addr;
  logic [31:0]          deq_bp_pc;

  modport slave (
    input  enq_valid, enq_pc, enq_pc_plus, enq_ilen32, enq_inst,
           enq_bp_taken, enq_bp_match, enq_bp_addr, enq_bp_pc, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_pc_plus, deq_ilen32, deq_inst,
           deq_bp_taken, deq_bp_match, deq_bp_addr, deq_bp_pc
  );

  modport master (
    output enq_valid, enq_pc, enq_pc_plus, enq_ilen32, enq_inst,
           enq_bp_taken, enq_bp_match, enq_bp_addr, enq_bp_pc, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_pc_plus, deq_ilen32, deq_inst,
           deq_bp_taken, deq_bp_match, deq_bp_addr, deq_bp_pc
  );
endinterface

// File: rtl/ifu_ibuf.sv
// Instruction buffer between fetch and decode: circular FIFO with flush and almost-full hint.
// Optional zero-latency empty-buffer bypass enabled by defining IBUF_BYPASS_EN.
module ifu_ibuf #(
  parameter int DEPTH     = 4,
  parameter int BP_ADDR_W = 4,
  parameter int AFULL_TH  = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  ifu_ibuf_if.slave              ibuf,
  output logic [$clog2(DEPTH):0] ibuf_count,
  output logic                   ibuf_afull
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          pc_plus;
    logic                 ilen32;
    logic [31:0]          inst;
    logic                 bp_taken;
    logic                 bp_match;
    logic [BP_ADDR_W-1:0] bp_addr;
    logic [31:0]          bp_pc;
  } entry_t;

  entry_t        mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r, count_r;
  logic          afull_r;

  logic [PW-1:0] rd_ptr_nxt_s, wr_ptr_nxt_s, count_nxt_s;
  logic          empty_s, full_s, bypass_s, enq_fire_s, deq_fire_s, afull_nxt_s;
  logic          deq_valid_s;
  entry_t        enq_entry_s, head_s, deq_entry_s;

  assign empty_s = (rd_ptr_r == wr_ptr_r);
  // Same slot index but opposite lap bit means the writer is a full lap ahead.
  assign full_s  = (rd_ptr_r[AW-1:0] == wr_ptr_r[AW-1:0]) && (rd_ptr_r[AW] != wr_ptr_r[AW]);

  assign enq_entry_s = '{pc:       ibuf.enq_pc,
                         pc_plus:  ibuf.enq_pc_plus,
                         ilen32:   ibuf.enq_ilen32,
                         inst:     ibuf.enq_inst,
                         bp_taken: ibuf.enq_bp_taken,
                         bp_match: ibuf.enq_bp_match,
                         bp_addr:  ibuf.enq_bp_addr,
                         bp_pc:    ibuf.enq_bp_pc};
  assign head_s = mem_r[rd_ptr_r[AW-1:0]];

  // Handshake decode, bypass selection and next pointer/occupancy computation.
  always_comb begin
    bypass_s    = 1'b0;
    deq_valid_s = !empty_s;
    deq_entry_s = head_s;
`ifdef IBUF_BYPASS_EN
    bypass_s = empty_s && ibuf.enq_valid && ibuf.deq_ready && !flush;
    if (empty_s) begin
      deq_valid_s = ibuf.enq_valid && !flush;
      deq_entry_s = enq_entry_s;
    end else begin
      deq_valid_s = 1'b1;
      deq_entry_s = head_s;
    end
`endif
    enq_fire_s = ibuf.enq_valid && !full_s && !flush && !bypass_s;
    deq_fire_s = !empty_s && ibuf.deq_ready && !flush;

    if (flush) begin
      rd_ptr_nxt_s = PTR_ZERO;
      wr_ptr_nxt_s = PTR_ZERO;
    end else begin
      rd_ptr_nxt_s = deq_fire_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      wr_ptr_nxt_s = enq_fire_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    end
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    afull_nxt_s = ((32'(DEPTH) - 32'(count_nxt_s)) <= 32'(AFULL_TH));
  end

  // Pointer, occupancy and almost-full state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= PTR_ZERO;
      afull_r  <= 1'b0;
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
      afull_r  <= afull_nxt_s;
    end
  end

  // Entry storage write; contents are left unreset since validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (enq_fire_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= enq_entry_s;
    end
  end

  assign ibuf.enq_ready    = !full_s;
  assign ibuf.deq_valid    = deq_valid_s;
  assign ibuf.deq_pc       = deq_entry_s.pc;
  assign ibuf.deq_pc_plus  = deq_entry_s.pc_plus;
  assign ibuf.deq_ilen32   = deq_entry_s.ilen32;
  assign ibuf.deq_inst     = deq_entry_s.inst;
  assign ibuf.deq_bp_taken = deq_entry_s.bp_taken;
  assign ibuf.deq_bp_match = deq_entry_s.bp_match;
  assign ibuf.deq_bp_addr  = deq_entry_s.bp_addr;
  assign ibuf.deq_bp_pc    = deq_entry_s.bp_pc;
  assign ibuf_count        = count_r;
  assign ibuf_afull        = afull_r;
endmodule

// File: tb/tb_ifu_ibuf.sv
// Randomized self-checking bench for ifu_ibuf: queue-based reference model plus directed literal checks.
module tb_ifu_ibuf;
  localparam int DEPTH = 4;
  localparam int BPW   = 4;
  localparam int ATH   = 1;

  typedef struct packed {
    logic [31:0]    pc;
    logic [31:0]    pc_plus;
    logic           ilen32;
    logic [31:0]    inst;
    logic           bp_taken;
    logic           bp_match;
    logic [BPW-1:0] bp_addr;
    logic [31:0]    bp_pc;
  } ent_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] count;
  logic       afull;
  int         n_checks = 0;
  int         n_fail = 0;

  ifu_ibuf_if #(.BP_ADDR_W(BPW)) ifc ();

  ifu_ibuf #(.DEPTH(DEPTH), .BP_ADDR_W(BPW), .AFULL_TH(ATH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .ibuf       (ifc),
    .ibuf_count (count),
    .ibuf_afull (afull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic dr, input logic fl);
    logic il;
    il = 1'($urandom_range(0, 1));
    ifc.enq_valid    = ev;
    ifc.enq_pc       = pc;
    ifc.enq_ilen32   = il;
    ifc.enq_pc_plus  = pc + (il ? 32'd4 : 32'd2);
    ifc.enq_inst     = $urandom;
    ifc.enq_bp_taken = 1'($urandom_range(0, 1));
    ifc.enq_bp_match = 1'($urandom_range(0, 1));
    ifc.enq_bp_addr  = 4'($urandom_range(0, 15));
    ifc.enq_bp_pc    = $urandom;
    ifc.deq_ready    = dr;
    flush            = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an in-order queue of accepted entries.
  ent_t q[$];
  ent_t in_e, dq_e, e_ent;
  logic e_fire, d_fire, m_flush, exp_ready, exp_valid, byp;
  int   sz;

  always begin
    @(negedge clk);
    e_fire  = 1'b0;
    d_fire  = 1'b0;
    m_flush = flush;
    if (rstn) begin
      in_e = {ifc.enq_pc, ifc.enq_pc_plus, ifc.enq_ilen32, ifc.enq_inst,
              ifc.enq_bp_taken, ifc.enq_bp_match, ifc.enq_bp_addr, ifc.enq_bp_pc};
      dq_e = {ifc.deq_pc, ifc.deq_pc_plus, ifc.deq_ilen32, ifc.deq_inst,
              ifc.deq_bp_taken, ifc.deq_bp_match, ifc.deq_bp_addr, ifc.deq_bp_pc};
      sz        = q.size();
      exp_ready = (sz < DEPTH);
      exp_valid = (sz > 0);
      byp       = 1'b0;
`ifdef IBUF_BYPASS_EN
      if (sz == 0 && ifc.enq_valid && !flush) exp_valid = 1'b1;
      byp = (sz == 0) && ifc.enq_valid && ifc.deq_ready && !flush;
`endif
      chk("enq_ready", ifc.enq_ready, exp_ready);
      chk("deq_valid", ifc.deq_valid, exp_valid);
      chk("ibuf_count", count, sz);
      chk("ibuf_afull", afull, (DEPTH - sz) <= ATH);
      if (exp_valid) chk("deq_fields", dq_e, (sz > 0) ? q[0] : in_e);
      e_fire = ifc.enq_valid && exp_ready && !flush && !byp;
      d_fire = (sz > 0) && ifc.deq_ready && !flush;
      e_ent  = in_e;
    end
    @(posedge clk);
    if (!rstn || m_flush) begin
      q.delete();
    end else begin
      if (d_fire) void'(q.pop_front());
      if (e_fire) q.push_back(e_ent);
    end
  end

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_count", count, 3'd0);
    chk("rst_enq_ready", ifc.enq_ready, 1'b1);
    chk("rst_deq_valid", ifc.deq_valid, 1'b0);
    chk("rst_afull", afull, 1'b0);
    cyc();
    rstn = 1'b1;

    // Back-to-back stream with decode always ready.
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
      @(negedge clk);
`ifdef IBUF_BYPASS_EN
      if (i < 3) begin
        chk("byp_stream_pc", ifc.deq_pc, 32'h1000 + 32'(4 * i));
        chk("byp_stream_count", count, 3'd0);
      end
`else
      if (i > 0) begin
        chk("stream_pc", ifc.deq_pc, 32'h1000 + 32'(4 * (i - 1)));
        chk("stream_count", count, 3'd1);
      end
`endif
      cyc();
    end

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1100 + 32'(4 * i), 1'b0, 1'b0);
      @(negedge clk);
      if (i == 3) begin
        chk("fill3_count", count, 3'd3);
        chk("fill3_afull", afull, 1'b1);
        chk("fill3_ready", ifc.enq_ready, 1'b1);
      end
      cyc();
    end
    drive(1'b1, 32'h1200, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", count, 3'd4);
    chk("full_ready", ifc.enq_ready, 1'b0);
    cyc();
    drive(1'b1, 32'h1300, 1'b1, 1'b0);
    @(negedge clk);
    chk("full_refuse_count", count, 3'd4);
    chk("full_head_pc", ifc.deq_pc, 32'h1100);
    cyc();
    drive(1'b1, 32'h1400, 1'b1, 1'b1);
    @(negedge clk);
    chk("deq_full_count", count, 3'd3);
    chk("deq_full_head", ifc.deq_pc, 32'h1104);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_count", count, 3'd0);
    chk("flush_valid", ifc.deq_valid, 1'b0);
    cyc();
    drive(1'b1, 32'h2000, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_flush_valid", ifc.deq_valid, 1'b1);
    chk("post_flush_pc", ifc.deq_pc, 32'h2000);
    chk("post_flush_count", count, 3'd1);
    cyc();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();

`ifdef IBUF_BYPASS_EN
    drive(1'b1, 32'h3000, 1'b1, 1'b0);
    @(negedge clk);
    chk("byp_valid", ifc.deq_valid, 1'b1);
    chk("byp_pc", ifc.deq_pc, 32'h3000);
    chk("byp_count", count, 3'd0);
    cyc();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("byp_after_count", count, 3'd0);
    cyc();
`endif

    // Steady stream with random decode stalls, across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h4000 + 32'(4 * i), ($urandom_range(0, 3) != 0), 1'b0);
      cyc();
    end

    // Fully random traffic with occasional flushes and one asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rstn = 1'b0;
        #2;
        chk("async_rst_count", count, 3'd0);
        chk("async_rst_valid", ifc.deq_valid, 1'b0);
        cyc();
        cyc();
        rstn = 1'b1;
      end
      drive(($urandom_range(0, 9) < 7), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
      cyc();
    end

    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (6) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
